// File: rtl/walk_phase_scheduler_pkg.sv
// Shared light and phase encodings for the walk phase scheduler family.
// Also holds the helper used to size the phase timer.
package walk_phase_scheduler_pkg;

    typedef enum logic [2:0] {
        S_WGRN   = 3'd0,
        S_WYLW   = 3'd1,
        S_ALLRED = 3'd2,
        S_PGRN   = 3'd3,
        S_PYLW   = 3'd4,
        S_WALK   = 3'd5,
        S_FLASH  = 3'd6
    } state_t;

    localparam logic [2:0] GRN = 3'b100;
    localparam logic [2:0] YLW = 3'b010;
    localparam logic [2:0] RED = 3'b001;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/walk_phase_scheduler_phase_timer.sv
// Per-phase tick counter: clears on phase change, otherwise counts up and
// saturates; done flags that the count has reached the supplied limit.
module phase_timer #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [WIDTH-1:0] limit,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count != '1) begin
            count <= count + 1'b1;
        end
    end

    assign done = (count >= limit);

endmodule

// File: rtl/walk_phase_scheduler.sv
// Washington/Prospect intersection controller with a protected pedestrian
// walk phase; one clock tick represents 5 s.
module walk_phase_scheduler
    import walk_phase_scheduler_pkg::*;
#(
    parameter int unsigned MIN_GRN_W    = 2,
    parameter int unsigned MIN_GRN_P    = 1,
    parameter int unsigned MAX_GRN_P    = 3,
    parameter int unsigned YLW_TICKS    = 1,
    parameter int unsigned ALLRED_TICKS = 1,
    parameter int unsigned WALK_TICKS   = 2,
    parameter int unsigned FLASH_TICKS  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       car_present,
    input  logic       ped_button,
    output logic [2:0] light_wash,
    output logic [2:0] light_pros,
    output logic       walk,
    output logic       dont_walk_flash,
    output logic [2:0] phase
);

    localparam int unsigned MAX_PARAM = max2(max2(max2(MIN_GRN_W, MIN_GRN_P), max2(MAX_GRN_P, YLW_TICKS)),
                                             max2(max2(ALLRED_TICKS, WALK_TICKS), FLASH_TICKS));
    localparam int unsigned TW = $clog2(MAX_PARAM) + 1;

    localparam logic [TW-1:0] L_MINW  = TW'(MIN_GRN_W - 1);
    localparam logic [TW-1:0] L_MINP  = TW'(MIN_GRN_P - 1);
    localparam logic [TW-1:0] L_MAXP  = TW'(MAX_GRN_P - 1);
    localparam logic [TW-1:0] L_YLW   = TW'(YLW_TICKS - 1);
    localparam logic [TW-1:0] L_AR    = TW'(ALLRED_TICKS - 1);
    localparam logic [TW-1:0] L_WALK  = TW'(WALK_TICKS - 1);
    localparam logic [TW-1:0] L_FLASH = TW'(FLASH_TICKS - 1);

    state_t         state, state_next;
    state_t         target, target_next;
    logic           ped_pending, ped_next;
    logic           timer_clear, timer_done;
    logic [TW-1:0]  limit;

    phase_timer #(.WIDTH(TW)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (timer_clear),
        .limit (limit),
        .done  (timer_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_WGRN;
            target      <= S_PGRN;
            ped_pending <= 1'b0;
        end else begin
            state       <= state_next;
            target      <= target_next;
            ped_pending <= ped_next;
        end
    end

    always_comb begin
        state_next  = state;
        target_next = target;
        limit       = '0;
        case (state)
            S_WGRN: begin
                limit = L_MINW;
                if (timer_done && (car_present || ped_pending)) begin
                    state_next  = S_WYLW;
                    target_next = ped_pending ? S_WALK : S_PGRN;
                end
            end
            S_WYLW: begin
                limit = L_YLW;
                if (timer_done) state_next = S_ALLRED;
            end
            S_ALLRED: begin
                limit = L_AR;
                if (timer_done) state_next = target;
            end
            S_PGRN: begin
                // MIN <= MAX, so one limit picked by car_present covers both exit rules
                limit = car_present ? L_MAXP : L_MINP;
                if (timer_done) begin
                    state_next  = S_PYLW;
                    target_next = ped_pending ? S_WALK : S_WGRN;
                end
            end
            S_PYLW: begin
                limit = L_YLW;
                if (timer_done) state_next = S_ALLRED;
            end
            S_WALK: begin
                limit = L_WALK;
                if (timer_done) state_next = S_FLASH;
            end
            S_FLASH: begin
                limit = L_FLASH;
                if (timer_done) begin
                    state_next  = S_ALLRED;
                    target_next = S_WGRN;
                end
            end
            default: state_next = S_WGRN;
        endcase
    end

    assign timer_clear = (state_next != state);

    // Entering WALK clears the request even if the button is held on that edge
    always_comb begin
        ped_next = ped_pending;
        if (state_next == S_WALK && state != S_WALK) begin
            ped_next = 1'b0;
        end else if (state != S_WALK && ped_button) begin
            ped_next = 1'b1;
        end
    end

    always_comb begin
        light_wash      = RED;
        light_pros      = RED;
        walk            = 1'b0;
        dont_walk_flash = 1'b0;
        case (state)
            S_WGRN:  light_wash = GRN;
            S_WYLW:  light_wash = YLW;
            S_PGRN:  light_pros = GRN;
            S_PYLW:  light_pros = YLW;
            S_WALK:  walk = 1'b1;
            S_FLASH: dont_walk_flash = 1'b1;
            default: ;
        endcase
    end

    assign phase = state;

endmodule

// File: tb/tb_walk_phase_scheduler.sv
// Directed bench for walk_phase_scheduler: table of per-cycle inputs and
// expected phases, plus a hand-written asynchronous reset sequence.
module tb_walk_phase_scheduler;
    import walk_phase_scheduler_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       car_present = 1'b0;
    logic       ped_button = 1'b0;
    logic [2:0] light_wash, light_pros, phase;
    logic       walk, dont_walk_flash;

    int unsigned errors = 0;
    int unsigned checks = 0;

    typedef struct {
        logic   rst;
        logic   car;
        logic   ped;
        state_t exp;
    } vec_t;

    vec_t vecs[$];

    walk_phase_scheduler dut (
        .clk             (clk),
        .rst             (rst),
        .car_present     (car_present),
        .ped_button      (ped_button),
        .light_wash      (light_wash),
        .light_pros      (light_pros),
        .walk            (walk),
        .dont_walk_flash (dont_walk_flash),
        .phase           (phase)
    );

    always #5 clk = ~clk;

    // Expected {phase, wash, pros, walk, flash} for a given phase
    function automatic logic [10:0] expect_of(input state_t s);
        logic [2:0] w, p;
        logic       wk, fl;
        w = 3'b001; p = 3'b001; wk = 1'b0; fl = 1'b0;
        case (s)
            S_WGRN:  w = 3'b100;
            S_WYLW:  w = 3'b010;
            S_PGRN:  p = 3'b100;
            S_PYLW:  p = 3'b010;
            S_WALK:  wk = 1'b1;
            S_FLASH: fl = 1'b1;
            default: ;
        endcase
        return {3'(s), w, p, wk, fl};
    endfunction

    task automatic check_outputs(input string name, input state_t e);
        logic [10:0] act, exp;
        act = {phase, light_wash, light_pros, walk, dont_walk_flash};
        exp = expect_of(e);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {phase,wash,pros,walk,flash}=%b required %b", name, act, exp);
        end
        checks++;
        if (!(light_wash == 3'b001 || light_pros == 3'b001) || (walk && !(light_wash == 3'b001 && light_pros == 3'b001))) begin
            errors++;
            $display("FAIL %s_invariant: wash=%b pros=%b walk=%b required a RED side and walk only on all-red",
                     name, light_wash, light_pros, walk);
        end
    endtask

    task automatic step(input logic r, input logic c, input logic p, input state_t e, input string name);
        @(negedge clk);
        rst = r; car_present = c; ped_button = p;
        @(posedge clk);
        #1;
        check_outputs(name, e);
    endtask

    function automatic void add(input logic r, input logic c, input logic p, input state_t e);
        vec_t v;
        v.rst = r; v.car = c; v.ped = p; v.exp = e;
        vecs.push_back(v);
    endfunction

    initial begin
        // Idle after reset: Washington keeps green, timer saturates
        for (int i = 0; i < 3; i++) add(1, 0, 0, S_WGRN);
        for (int i = 0; i < 20; i++) add(0, 0, 0, S_WGRN);
        // One-cycle car pulse: Prospect gets exactly its minimum green
        add(0, 1, 0, S_WYLW);
        add(0, 0, 0, S_ALLRED);
        add(0, 0, 0, S_PGRN);
        add(0, 0, 0, S_PYLW);
        add(0, 0, 0, S_ALLRED);
        add(0, 0, 0, S_WGRN);
        add(0, 0, 0, S_WGRN);
        add(0, 0, 0, S_WGRN);
        // Pedestrian pulse; second press lands on the edge entering WALK and is dropped
        add(0, 0, 1, S_WGRN);
        add(0, 0, 0, S_WYLW);
        add(0, 0, 0, S_ALLRED);
        add(0, 0, 1, S_WALK);
        add(0, 0, 0, S_WALK);
        add(0, 0, 0, S_FLASH);
        add(0, 0, 0, S_ALLRED);
        add(0, 0, 0, S_WGRN);
        for (int i = 0; i < 4; i++) add(0, 0, 0, S_WGRN);
        // Continuous car from reset release: Prospect runs to max green
        add(1, 0, 0, S_WGRN);
        add(1, 0, 0, S_WGRN);
        add(0, 1, 0, S_WGRN);
        add(0, 1, 0, S_WYLW);
        add(0, 1, 0, S_ALLRED);
        add(0, 1, 0, S_PGRN);
        add(0, 1, 0, S_PGRN);
        add(0, 1, 0, S_PGRN);
        add(0, 1, 0, S_PYLW);
        add(0, 1, 0, S_ALLRED);
        add(0, 1, 0, S_WGRN);
        add(0, 1, 0, S_WGRN);
        add(0, 1, 0, S_WYLW);
        add(0, 1, 0, S_ALLRED);
        add(0, 1, 0, S_PGRN);
        // Car and pedestrian during Prospect green: walk served before Washington
        add(0, 1, 1, S_PGRN);
        add(0, 1, 0, S_PGRN);
        add(0, 1, 0, S_PYLW);
        add(0, 1, 0, S_ALLRED);
        add(0, 1, 0, S_WALK);
        add(0, 1, 0, S_WALK);
        add(0, 1, 0, S_FLASH);
        add(0, 1, 0, S_ALLRED);
        add(0, 1, 0, S_WGRN);
        add(0, 1, 0, S_WGRN);
        add(0, 1, 0, S_WYLW);

        #1;
        check_outputs("reset_state", S_WGRN);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].car, vecs[i].ped, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Asynchronous reset in the middle of WALK, with a press made during WALK
        step(1, 0, 0, S_WGRN, "ar_rst");
        step(0, 0, 1, S_WGRN, "ar_req");
        step(0, 0, 0, S_WYLW, "ar_wylw");
        step(0, 0, 0, S_ALLRED, "ar_allred");
        step(0, 0, 0, S_WALK, "ar_walk0");
        step(0, 0, 1, S_WALK, "ar_walk1");
        ped_button = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_outputs("ar_async", S_WGRN);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, S_WGRN, $sformatf("ar_after%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
